// File: rtl/uart_fifo_core.sv
// UART core with programmable baud divisor, 5-8 data bits, optional parity, 1/2 stop bits,
// TX/RX FIFOs, RTS/CTS flow control and sticky receive error flags.

module uart_fifo_core_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             wdata,
    input  logic                     wr,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         full;
    logic         empty;
    logic         do_wr;
    logic         do_rd;

    assign level = wptr - rptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic [7:0]                    tx_wdata,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic                          tx_idle,
    output logic [7:0]                    rx_rdata,
    input  logic                          rx_rd,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    input  logic                          err_clr,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          overrun,
    input  logic                          rx,
    input  logic                          cts_n,
    output logic                          tx,
    output logic                          rts_n
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] RTS_LVL  = LW'(FIFO_DEPTH - RTS_MARGIN);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_WAIT   = 3'd5;

    function automatic logic [7:0] width_mask(input logic [1:0] n);
        case (n)
            2'd0:    width_mask = 8'h1F;
            2'd1:    width_mask = 8'h3F;
            2'd2:    width_mask = 8'h7F;
            default: width_mask = 8'hFF;
        endcase
    endfunction

    // Baud generator; the divisor is reloaded only on wrap so a period is never cut short.
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (baud_cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    logic [7:0]    txf_rdata;
    logic [LW-1:0] txf_level;
    logic          txf_empty;
    logic          tx_pop;

    logic [2:0] tx_state;
    logic [4:0] tx_tcnt;
    logic [2:0] tx_bcnt;
    logic [2:0] tx_last;
    logic [7:0] tx_shift;
    logic       tx_par_en;
    logic       tx_par_bit;
    logic       tx_stop2;

    assign txf_empty = (txf_level == '0);
    assign tx_full   = (txf_level == FULL_LVL);
    assign tx_idle   = txf_empty && (tx_state == TX_IDLE);
    assign tx_pop    = tick && (tx_state == TX_IDLE) && !txf_empty && !cts_n;

    uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (tx_wdata),
        .wr    (tx_wr),
        .rd    (tx_pop),
        .rdata (txf_rdata),
        .level (txf_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_tcnt    <= '0;
            tx_bcnt    <= '0;
            tx_last    <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
            tx         <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state   <= TX_START;
                        tx_tcnt    <= '0;
                        tx_shift   <= txf_rdata;
                        tx_last    <= {1'b0, data_bit_num} + 3'd4;
                        tx_par_en  <= parity_en;
                        tx_par_bit <= (^(txf_rdata & width_mask(data_bit_num))) ^ parity_type;
                        tx_stop2   <= stop_bit_num;
                        tx         <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_tcnt == 5'd15) begin
                            tx_state <= TX_DATA;
                            tx_tcnt  <= '0;
                            tx_bcnt  <= '0;
                            tx       <= tx_shift[0];
                        end else begin
                            tx_tcnt <= tx_tcnt + 5'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_tcnt == 5'd15) begin
                            tx_tcnt <= '0;
                            if (tx_bcnt == tx_last) begin
                                if (tx_par_en) begin
                                    tx_state <= TX_PARITY;
                                    tx       <= tx_par_bit;
                                end else begin
                                    tx_state <= TX_STOP;
                                    tx       <= 1'b1;
                                end
                            end else begin
                                tx_bcnt  <= tx_bcnt + 3'd1;
                                tx_shift <= tx_shift >> 1;
                                tx       <= tx_shift[1];
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt + 5'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (tx_tcnt == 5'd15) begin
                            tx_state <= TX_STOP;
                            tx_tcnt  <= '0;
                            tx       <= 1'b1;
                        end else begin
                            tx_tcnt <= tx_tcnt + 5'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_tcnt == (tx_stop2 ? 5'd31 : 5'd15)) begin
                            tx_state <= TX_IDLE;
                            tx_tcnt  <= '0;
                        end else begin
                            tx_tcnt <= tx_tcnt + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic [2:0]    rx_state;
    logic [3:0]    rx_tcnt;
    logic [2:0]    rx_bcnt;
    logic [2:0]    rx_last;
    logic [7:0]    rx_data;
    logic          rx_par_en;
    logic          rx_par_type;
    logic          rx_par_bad;
    logic          rx_push;
    logic          rx_full;
    logic [LW-1:0] rxf_level;

    assign rx_push  = (rx_state == RX_STOP) && tick && (rx_tcnt == 4'd15);
    assign rx_full  = (rxf_level == FULL_LVL);
    assign rx_empty = (rxf_level == '0);
    assign rx_level = rxf_level;

    uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (rx_data),
        .wr    (rx_push),
        .rd    (rx_rd),
        .rdata (rx_rdata),
        .level (rxf_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_tcnt     <= '0;
            rx_bcnt     <= '0;
            rx_last     <= '0;
            rx_data     <= '0;
            rx_par_en   <= 1'b0;
            rx_par_type <= 1'b0;
            rx_par_bad  <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state    <= RX_START;
                        rx_tcnt     <= '0;
                        rx_bcnt     <= '0;
                        rx_data     <= '0;
                        rx_last     <= {1'b0, data_bit_num} + 3'd4;
                        rx_par_en   <= parity_en;
                        rx_par_type <= parity_type;
                        rx_par_bad  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tcnt == 4'd7) begin
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                            rx_tcnt  <= '0;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_data[rx_bcnt] <= rx_sync;
                            if (rx_bcnt == rx_last)
                                rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                            else
                                rx_bcnt <= rx_bcnt + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_par_bad <= rx_sync ^ (^rx_data) ^ rx_par_type;
                            rx_state   <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15)
                            rx_state <= rx_sync ? RX_IDLE : RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (rx_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic par_set;
    logic frm_set;
    logic ovr_set;

    assign par_set = rx_push && rx_par_en && rx_par_bad;
    assign frm_set = rx_push && !rx_sync;
    assign ovr_set = rx_push && rx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            rts_n        <= 1'b1;
        end else begin
            parity_error <= par_set ? 1'b1 : (err_clr ? 1'b0 : parity_error);
            frame_error  <= frm_set ? 1'b1 : (err_clr ? 1'b0 : frame_error);
            overrun      <= ovr_set ? 1'b1 : (err_clr ? 1'b0 : overrun);
            rts_n        <= (rxf_level >= RTS_LVL);
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized scoreboard bench for uart_fifo_core: loopback, line-driven RX frames, flow control, reset.

module tb_uart_fifo_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num;
    logic        parity_en;
    logic        parity_type;
    logic [7:0]  tx_wdata;
    logic        tx_wr;
    logic        tx_full;
    logic        tx_idle;
    logic [7:0]  rx_rdata;
    logic        rx_rd;
    logic        rx_empty;
    logic [2:0]  rx_level;
    logic        err_clr;
    logic        parity_error;
    logic        frame_error;
    logic        overrun;
    logic        rx_line;
    logic        cts_n;
    logic        tx;
    logic        rts_n;

    logic        loop_en;
    logic        rx_drv;
    bit          mon_en;
    logic [7:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(.FIFO_DEPTH(4), .DIV_W(16), .RTS_MARGIN(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_div     (baud_div),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .tx_wdata     (tx_wdata),
        .tx_wr        (tx_wr),
        .tx_full      (tx_full),
        .tx_idle      (tx_idle),
        .rx_rdata     (rx_rdata),
        .rx_rd        (rx_rd),
        .rx_empty     (rx_empty),
        .rx_level     (rx_level),
        .err_clr      (err_clr),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .rx           (rx_line),
        .cts_n        (cts_n),
        .tx           (tx),
        .rts_n        (rts_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a UART word keeps only its low nb bits; parity counts ones.
    function automatic logic [7:0] ref_word(input logic [7:0] d, input int nb);
        return 8'(int'(d) % (1 << nb));
    endfunction

    function automatic logic ref_parity(input logic [7:0] d, input int nb, input bit odd);
        int v;
        int ones;
        v = int'(d) % (1 << nb);
        ones = 0;
        while (v > 0) begin
            ones += v % 2;
            v /= 2;
        end
        return 1'(ones % 2) ^ odd;
    endfunction

    function automatic int bit_clks();
        return (int'(baud_div) + 1) * 16;
    endfunction

    task automatic set_cfg(input int nb, input int nstop, input bit pen, input bit odd);
        data_bit_num = 2'(nb - 5);
        stop_bit_num = (nstop == 2);
        parity_en    = pen;
        parity_type  = odd;
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        tx_wdata = d;
        tx_wr    = 1'b1;
        @(negedge clk);
        tx_wr    = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input int nb, input bit pen, input bit odd,
                           input bit bad_stop, input bit bad_par);
        int bc;
        bc = bit_clks();
        rx_drv = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_drv = d[i];
            repeat (bc) @(negedge clk);
        end
        if (pen) begin
            rx_drv = ref_parity(d, nb, odd) ^ bad_par;
            repeat (bc) @(negedge clk);
        end
        rx_drv = !bad_stop;
        repeat (bc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bc) @(negedge clk);
    endtask

    task automatic tx_decode(input int nb, input bit pen, input int bound, input bit raise_cts,
                             output logic [7:0] d, output logic p, output logic stopv, output bit found);
        int bc;
        bc = bit_clks();
        found = 0;
        d = '0;
        p = 1'b0;
        stopv = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (tx == 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (found) begin
            if (raise_cts) cts_n = 1'b1;
            repeat (bc / 2) @(negedge clk);
            for (int i = 0; i < nb; i++) begin
                repeat (bc) @(negedge clk);
                d[i] = tx;
            end
            if (pen) begin
                repeat (bc) @(negedge clk);
                p = tx;
            end
            repeat (bc) @(negedge clk);
            stopv = tx;
        end
    endtask

    task automatic wait_tx_idle(input int bound);
        int n;
        n = 0;
        while (!tx_idle && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_reached", {31'd0, tx_idle}, 32'd1);
    endtask

    // Scoreboard monitor: pops each RX head and compares it to the oldest expected word.
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            rx_rd = 1'b0;
            if (mon_en && !rst && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_rdata);
                end else begin
                    check("rx_word", {24'd0, rx_rdata}, {24'd0, exp_q.pop_front()});
                end
                rx_rd = 1'b1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] words [4];
        logic [7:0] got;
        logic       par;
        logic       stopv;
        bit         found;
        bit         low_seen;
        int         t;
        int         k;
        int         nb;
        int         ns;
        bit         pen;
        bit         odd;
        int         lvl;
        bit         exp_ovr;

        rst = 1'b1;
        baud_div = 16'd26;
        set_cfg(8, 1, 0, 0);
        tx_wdata = '0;
        tx_wr = 1'b0;
        err_clr = 1'b0;
        cts_n = 1'b0;
        rx_drv = 1'b1;
        loop_en = 1'b0;
        mon_en = 0;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_rts_n", {31'd0, rts_n}, 32'd1);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("rst_rx_level", {29'd0, rx_level}, 32'd0);
        check("rst_errors", {29'd0, parity_error, frame_error, overrun}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rts_n_after_reset", {31'd0, rts_n}, 32'd0);
        mon_en = 1;

        // 8N1, 0xA5, 432 clk per bit
        d = 8'hA5;
        push_tx(d);
        check("tx_idle_busy", {31'd0, tx_idle}, 32'd0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx == 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("a5_start_found", {31'd0, found}, 32'd1);
        t = 0;
        k = 0;
        while (!tx_idle && t < 6000) begin
            @(negedge clk);
            t++;
            if (k < 10 && t == 216 + 432 * k) begin
                check($sformatf("a5_bit%0d", k), {31'd0, tx},
                      (k == 0) ? 32'd0 : (k == 9) ? 32'd1 : {31'd0, d[k-1]});
                k++;
            end
        end
        check("a5_bits_sampled", k, 10);
        check("a5_idle_delay", t, 4320);

        // Loopback 7E2 with parity bit inspection
        baud_div = 16'd3;
        repeat (100) @(negedge clk);
        set_cfg(7, 2, 1, 0);
        loop_en = 1'b1;
        words[0] = 8'h55;
        words[1] = 8'h54;
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back(ref_word(words[w], 7));
            push_tx(words[w]);
            tx_decode(7, 1, 200, 0, got, par, stopv, found);
            check("lb_found", {31'd0, found}, 32'd1);
            check("lb_tx_data", {24'd0, got}, {24'd0, ref_word(words[w], 7)});
            check("lb_parity_bit", {31'd0, par}, {31'd0, ref_parity(words[w], 7, 0)});
            check("lb_stop", {31'd0, stopv}, 32'd1);
            wait_tx_idle(2000);
            repeat (2 * bit_clks()) @(negedge clk);
        end
        check("lb_no_errors", {29'd0, parity_error, frame_error, overrun}, 32'd0);

        // Randomized loopback configurations, two back-to-back words each
        for (int r = 0; r < 6; r++) begin
            nb  = 5 + int'($urandom_range(0, 3));
            ns  = 1 + int'($urandom_range(0, 1));
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            set_cfg(nb, ns, pen, odd);
            for (int w = 0; w < 2; w++) begin
                d = 8'($urandom);
                exp_q.push_back(ref_word(d, nb));
                push_tx(d);
            end
            wait_tx_idle(4000);
            repeat (2 * bit_clks()) @(negedge clk);
        end
        check("rand_no_errors", {29'd0, parity_error, frame_error, overrun}, 32'd0);
        check("rand_drained", exp_q.size(), 0);
        loop_en = 1'b0;

        // Framing error: word still delivered, flag sticky until err_clr
        set_cfg(8, 1, 0, 0);
        d = 8'($urandom);
        exp_q.push_back(d);
        send_rx(d, 8, 0, 0, 1, 0);
        check("frame_error_set", {31'd0, frame_error}, 32'd1);
        check("frame_no_parity", {31'd0, parity_error}, 32'd0);
        pulse_clr();
        check("frame_error_clr", {31'd0, frame_error}, 32'd0);

        // Parity error with odd parity
        set_cfg(8, 1, 1, 1);
        d = 8'($urandom);
        exp_q.push_back(d);
        send_rx(d, 8, 1, 1, 0, 1);
        check("parity_error_set", {31'd0, parity_error}, 32'd1);
        check("parity_no_frame", {31'd0, frame_error}, 32'd0);
        pulse_clr();
        check("parity_error_clr", {31'd0, parity_error}, 32'd0);

        // Overrun and RTS with no pops
        set_cfg(8, 1, 0, 0);
        mon_en = 0;
        repeat (4) @(negedge clk);
        lvl = 0;
        exp_ovr = 0;
        for (int f = 0; f < 5; f++) begin
            d = 8'($urandom);
            if (lvl < 4) begin
                exp_q.push_back(d);
                lvl++;
            end else begin
                exp_ovr = 1;
            end
            send_rx(d, 8, 0, 0, 0, 0);
            check($sformatf("ovr_level%0d", f), {29'd0, rx_level}, lvl);
            check($sformatf("ovr_rts_n%0d", f), {31'd0, rts_n}, (lvl >= 2) ? 32'd1 : 32'd0);
            check($sformatf("ovr_flag%0d", f), {31'd0, overrun}, {31'd0, exp_ovr});
        end
        mon_en = 1;
        t = 0;
        while (!rx_empty && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("ovr_drained_level", {29'd0, rx_level}, 32'd0);
        check("ovr_rts_n_low", {31'd0, rts_n}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // CTS flow control
        cts_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            words[w] = 8'($urandom);
            push_tx(words[w]);
        end
        low_seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!tx) low_seen = 1;
        end
        check("cts_hold_tx", {31'd0, low_seen}, 32'd0);
        check("cts_hold_busy", {31'd0, tx_idle}, 32'd0);
        cts_n = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tx_decode(8, 0, (w == 0) ? 2 * bit_clks() : bit_clks(), (w == 2), got, par, stopv, found);
            check($sformatf("cts_frame%0d_found", w), {31'd0, found}, 32'd1);
            check($sformatf("cts_frame%0d_data", w), {24'd0, got}, {24'd0, words[w]});
            check($sformatf("cts_frame%0d_stop", w), {31'd0, stopv}, 32'd1);
        end
        wait_tx_idle(1000);
        for (int w = 0; w < 4; w++) push_tx(8'($urandom));
        check("tx_full_set", {31'd0, tx_full}, 32'd1);
        low_seen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (!tx) low_seen = 1;
        end
        check("cts_hold2_tx", {31'd0, low_seen}, 32'd0);

        // Reset mid-frame
        cts_n = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx == 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_frame_found", {31'd0, found}, 32'd1);
        push_tx(8'($urandom));
        check("tx_full_refill", {31'd0, tx_full}, 32'd1);
        repeat (3 * bit_clks()) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("midrst_tx_full", {31'd0, tx_full}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // One-cycle glitch on rx gives no word
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * bit_clks()) @(negedge clk);
        check("glitch_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("glitch_rx_level", {29'd0, rx_level}, 32'd0);
        check("glitch_no_errors", {29'd0, parity_error, frame_error, overrun}, 32'd0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
